fifo_dc_drain: RTL and testbench

//   Read-side master for fifo_dc. Issues fifo_dc pops, absorbs its 1-cycle read latency, and

---
 rtl/fifo_dc_drain.sv | 127 ++++++++++++
 tb/tb_fifo_dc_drain.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_dc_drain.sv
// Read-side master for fifo_dc: issues pops, absorbs the one-cycle read latency in a
// two-entry skid buffer and presents the words as a burst-framed valid/ready stream.
module fifo_dc_drain #(
   parameter int C_WIDTH          = 8,
   parameter int C_LOG_FIFO_DEPTH = 3,
   parameter int C_BURST_LEN      = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   input  logic                        fifo_empty,
   input  logic [C_LOG_FIFO_DEPTH:0]   fifo_count,
   output logic                        fifo_rd_en,
   input  logic [C_WIDTH-1:0]          fifo_data,
   output logic [C_WIDTH-1:0]          m_data,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic                        m_last,
   output logic                        burst_done,
   output logic [15:0]                 words_out
);

   localparam int C_BEAT_W = (C_BURST_LEN > 1) ? $clog2(C_BURST_LEN) : 1;
   localparam logic [C_BEAT_W-1:0] C_LAST_BEAT = C_BEAT_W'(C_BURST_LEN - 1);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_e;

   occ_e                occ_q, occ_d;
   logic                pending_q, pending_d;
   logic [C_WIDTH-1:0]  head_q, head_d;
   logic [C_WIDTH-1:0]  spare_q, spare_d;
   logic [C_BEAT_W-1:0] beat_q, beat_d;
   logic                burst_done_q, burst_done_d;
   logic [15:0]         words_q, words_d;
   logic                acc;
   logic [2:0]          in_flight;

   assign m_valid    = (occ_q != EMPTY);
   assign m_data     = head_q;
   assign m_last     = m_valid & (beat_q == C_LAST_BEAT);
   assign burst_done = burst_done_q;
   assign words_out  = words_q;
   assign acc        = m_valid & m_ready;

   // Words already buffered or still in flight must never exceed the two buffer slots,
   // counting the slot freed by this cycle's handshake.
   assign in_flight  = {1'b0, occ_q} + {2'b0, pending_q};
   assign fifo_rd_en = enable & ~fifo_empty & (in_flight < (3'd2 + {2'b0, acc}));

   always_comb begin
      occ_d        = occ_q;
      pending_d    = fifo_rd_en;
      head_d       = head_q;
      spare_d      = spare_q;
      beat_d       = beat_q;
      burst_done_d = acc & m_last;
      words_d      = words_q + {15'b0, acc};

      if (acc) begin
         beat_d = m_last ? '0 : beat_q + C_BEAT_W'(1);
      end

      // The spare slot always holds the younger word, so it shifts into head on a handshake.
      case (occ_q)
         EMPTY: begin
            if (pending_q) begin
               head_d = fifo_data;
               occ_d  = ONE;
            end
         end
         ONE: begin
            case ({pending_q, acc})
               2'b10: begin
                  spare_d = fifo_data;
                  occ_d   = TWO;
               end
               2'b01: occ_d = EMPTY;
               2'b11: head_d = fifo_data;
               default: occ_d = ONE;
            endcase
         end
         TWO: begin
            if (acc) begin
               head_d = spare_q;
               if (pending_q) begin
                  spare_d = fifo_data;
               end else begin
                  occ_d = ONE;
               end
            end
         end
         default: occ_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q        <= EMPTY;
         pending_q    <= 1'b0;
         head_q       <= '0;
         spare_q      <= '0;
         beat_q       <= '0;
         burst_done_q <= 1'b0;
         words_q      <= '0;
      end else begin
         occ_q        <= occ_d;
         pending_q    <= pending_d;
         head_q       <= head_d;
         spare_q      <= spare_d;
         beat_q       <= beat_d;
         burst_done_q <= burst_done_d;
         words_q      <= words_d;
      end
   end

   // fifo_count is status only; it is used here to cross-check the FIFO's own flags.
   a_empty_matches_count : assert property (@(posedge clk) disable iff (rst)
      fifo_empty == (fifo_count == '0));

   a_no_overfill : assert property (@(posedge clk) disable iff (rst)
      !(occ_q == TWO && pending_q && !acc));

endmodule

// File: tb/tb_fifo_dc_drain.sv
// Self-checking bench for fifo_dc_drain: a behavioural fifo_dc feeds the main instance and a
// scoreboard queue checks order, framing and counters; a second C_BURST_LEN=1 build checks wrap.
module tb_fifo_dc_drain;

   localparam int W  = 8;
   localparam int LD = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          m_ready = 1'b0;
   logic          fifo_empty;
   logic [LD:0]   fifo_count;
   logic          fifo_rd_en;
   logic [W-1:0]  fifo_data;
   logic [W-1:0]  m_data;
   logic          m_valid, m_last, burst_done;
   logic [15:0]   words_out;

   logic          enable1 = 1'b0;
   logic          ready1 = 1'b0;
   logic          fifo_rd_en1;
   logic [W-1:0]  m_data1;
   logic          m_valid1, m_last1, burst_done1;
   logic [15:0]   words_out1;

   logic          wrEn = 1'b0;
   logic [W-1:0]  wrData = '0;
   logic [W-1:0]  mem [8];
   logic [2:0]    wrPtr, rdPtr;

   int            vecCount = 0;
   int            errCount = 0;
   logic [W-1:0]  sbq [$];
   int            outstanding = 0;
   int            tbBeat = 0;
   logic [15:0]   wordsModel = '0;
   logic          expBd = 1'b0;
   int            popCount = 0;
   int            bdCount = 0;

   always #5 clk = ~clk;

   fifo_dc_drain #(.C_WIDTH(W), .C_LOG_FIFO_DEPTH(LD), .C_BURST_LEN(4)) dut (
      .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_count(fifo_count), .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .burst_done(burst_done), .words_out(words_out)
   );

   fifo_dc_drain #(.C_WIDTH(W), .C_LOG_FIFO_DEPTH(LD), .C_BURST_LEN(1)) dut1 (
      .clk(clk), .rst(rst), .enable(enable1), .fifo_empty(1'b0),
      .fifo_count(4'd8), .fifo_rd_en(fifo_rd_en1), .fifo_data(8'hA5),
      .m_data(m_data1), .m_valid(m_valid1), .m_ready(ready1), .m_last(m_last1),
      .burst_done(burst_done1), .words_out(words_out1)
   );

   // Behavioural fifo_dc: depth 8, registered read data, zero when no pop was issued.
   assign fifo_empty = (fifo_count == '0);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr      <= '0;
         rdPtr      <= '0;
         fifo_count <= '0;
         fifo_data  <= '0;
      end else begin
         if (wrEn && fifo_count < 4'd8) begin
            mem[wrPtr] <= wrData;
            wrPtr      <= wrPtr + 3'd1;
         end
         if (fifo_rd_en) begin
            fifo_data <= mem[rdPtr];
            rdPtr     <= rdPtr + 3'd1;
         end else begin
            fifo_data <= '0;
         end
         fifo_count <= fifo_count + {3'b0, (wrEn && fifo_count < 4'd8)} - {3'b0, fifo_rd_en};
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vecCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected,
                  $time);
      end
   endtask

   // Scoreboard monitor: handshakes are judged at negedge, ahead of the edge that commits them.
   always @(negedge clk) begin
      logic          acc;
      logic [W-1:0]  expWord;
      if (rst) begin
         sbq.delete();
         outstanding = 0;
         tbBeat      = 0;
         wordsModel  = '0;
         expBd       = 1'b0;
      end else begin
         acc = m_valid & m_ready;
         if (fifo_rd_en) popCount++;
         if (burst_done) bdCount++;
         if (fifo_rd_en && fifo_empty) checkOutput("rdWhileEmpty", 1, 0);
         if (outstanding + int'(fifo_rd_en) - int'(acc) > 2)
            checkOutput("credit", outstanding + int'(fifo_rd_en) - int'(acc), 2);
         checkOutput("wordsOut", words_out, wordsModel);
         checkOutput("burstDone", burst_done, expBd);
         expBd = 1'b0;
         if (acc) begin
            if (sbq.size() == 0) begin
               checkOutput("spuriousWord", m_data, 32'hFFFF_FFFF);
            end else begin
               expWord = sbq.pop_front();
               checkOutput("data", m_data, expWord);
            end
            checkOutput("last", m_last, tbBeat == 3);
            expBd      = (tbBeat == 3);
            tbBeat     = (tbBeat + 1) % 4;
            wordsModel = wordsModel + 16'd1;
         end
         outstanding = outstanding + int'(fifo_rd_en) - int'(acc);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [W-1:0] word, input logic toggleReady);
      wrEn   = 1'b1;
      wrData = word;
      sbq.push_back(word);
      if (toggleReady) m_ready = ~m_ready;
      step(1);
      wrEn   = 1'b0;
   endtask

   task automatic drainAll(input string tag, input logic toggleReady);
      int budget;
      budget = 60;
      while ((sbq.size() != 0 || m_valid) && budget > 0) begin
         if (toggleReady) m_ready = ~m_ready;
         step(1);
         budget--;
      end
      checkOutput(tag, sbq.size(), 0);
   endtask

   initial begin
      int popStart;
      step(2);
      rst = 1'b0;
      step(1);
      checkOutput("rstValid", m_valid, 0);
      checkOutput("rstData", m_data, 0);
      checkOutput("rstLast", m_last, 0);
      checkOutput("rstBurstDone", burst_done, 0);
      checkOutput("rstWords", words_out, 0);
      checkOutput("rstRdEn", fifo_rd_en, 0);

      // 1: preloaded FIFO, always-ready consumer, latency and full throughput.
      for (int i = 0; i < 8; i++) applyStimulus(8'h10 + 8'(i), 1'b0);
      step(1);
      bdCount = 0;
      enable  = 1'b1;
      m_ready = 1'b1;
      #1;
      checkOutput("t1RdEn", fifo_rd_en, 1);
      checkOutput("t1ValidN", m_valid, 0);
      step(1);
      checkOutput("t1ValidN1", m_valid, 0);
      step(1);
      checkOutput("t1FirstData", m_data, 8'h10);
      for (int i = 0; i < 8; i++) begin
         checkOutput("t1Stream", m_valid, 1);
         step(1);
      end
      checkOutput("t1Words", words_out, 16'd8);
      checkOutput("t1Empty", m_valid, 0);
      step(1);
      checkOutput("t1BurstDones", bdCount, 2);

      // 2: consumer ready toggling every cycle while words arrive.
      for (int i = 0; i < 8; i++) applyStimulus(8'h30 + 8'(i), 1'b1);
      drainAll("t2Drain", 1'b1);

      // 3: stalled consumer, only two pops fit the buffer.
      m_ready  = 1'b0;
      popStart = popCount;
      for (int i = 0; i < 5; i++) applyStimulus(8'h40 + 8'(i), 1'b0);
      step(4);
      checkOutput("t3Pops", popCount - popStart, 2);
      checkOutput("t3Count", fifo_count, 3);
      checkOutput("t3Valid", m_valid, 1);
      checkOutput("t3Head", m_data, 8'h40);
      step(3);
      checkOutput("t3HeadHeld", m_data, 8'h40);
      m_ready = 1'b1;
      drainAll("t3Drain", 1'b0);

      // 4: enable withdrawn after two pops, then restored.
      enable = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(8'h50 + 8'(i), 1'b0);
      step(1);
      popStart = popCount;
      enable   = 1'b1;
      step(2);
      enable   = 1'b0;
      step(6);
      checkOutput("t4Pops", popCount - popStart, 2);
      checkOutput("t4Count", fifo_count, 2);
      checkOutput("t4Delivered", sbq.size(), 2);
      enable = 1'b1;
      drainAll("t4Drain", 1'b0);

      // 5: asynchronous reset with a part-done burst and a full skid buffer.
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(1);
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(8'h60 + 8'(i), 1'b0);
      step(3);
      m_ready = 1'b1;
      step(2);
      m_ready = 1'b0;
      step(3);
      checkOutput("t5PreValid", m_valid, 1);
      checkOutput("t5PreHead", m_data, 8'h62);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("t5AsyncValid", m_valid, 0);
      checkOutput("t5AsyncData", m_data, 0);
      checkOutput("t5AsyncLast", m_last, 0);
      checkOutput("t5AsyncWords", words_out, 0);
      checkOutput("t5AsyncRdEn", fifo_rd_en, 0);
      step(1);
      rst     = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(8'h70 + 8'(i), 1'b0);
      drainAll("t5Drain", 1'b0);
      checkOutput("t5Words", words_out, 16'd4);

      // 6: single-word bursts, words_out wrap.
      enable  = 1'b0;
      enable1 = 1'b1;
      ready1  = 1'b1;
      for (int i = 0; i < 70000; i++) begin
         if (words_out1 == 16'hFFFE) break;
         step(1);
      end
      ready1 = 1'b0;
      step(1);
      checkOutput("t6Reach", words_out1, 16'hFFFE);
      checkOutput("t6Valid", m_valid1, 1);
      checkOutput("t6Last", m_last1, 1);
      ready1 = 1'b1;
      step(1);
      ready1 = 1'b0;
      checkOutput("t6WordsFFFF", words_out1, 16'hFFFF);
      checkOutput("t6BurstDone", burst_done1, 1);
      checkOutput("t6LastAgain", m_last1, 1);
      ready1 = 1'b1;
      step(1);
      ready1 = 1'b0;
      checkOutput("t6Wrap", words_out1, 16'h0000);
      step(2);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
